// File: rtl/riscv_test_monitor.sv
// Watches the core fetch stream and reports a sticky test verdict (pass/fail/timeout/hang)
// together with run counters and a circular history of the last distinct fetch PCs.
module riscv_test_monitor #(
  parameter int              PC_W           = 32,
  parameter logic [PC_W-1:0] PASS_ADDR      = 32'h8000012c,
  parameter logic [PC_W-1:0] FAIL_ADDR      = 32'h80000130,
  parameter int              TIMEOUT_CYCLES = 1000,
  parameter int              STALL_LIMIT    = 64,
  parameter int              CNT_W          = 32,
  parameter int              HIST_DEPTH     = 8,
  parameter int              HIST_AW        = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               fetch_valid_i,
  input  logic [PC_W-1:0]    fetch_pc_i,
  input  logic [HIST_AW-1:0] hist_idx_i,
  output logic               running_o,
  output logic               done_o,
  output logic [2:0]         status_o,
  output logic [CNT_W-1:0]   cycle_count_o,
  output logic [CNT_W-1:0]   fetch_count_o,
  output logic [PC_W-1:0]    final_pc_o,
  output logic [PC_W-1:0]    hist_pc_o,
  output logic [HIST_AW:0]   hist_count_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [2:0] ST_NONE    = 3'd0;
  localparam logic [2:0] ST_PASS    = 3'd1;
  localparam logic [2:0] ST_FAIL    = 3'd2;
  localparam logic [2:0] ST_TIMEOUT = 3'd3;
  localparam logic [2:0] ST_HANG    = 3'd4;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STALL_LAST   = CNT_W'(STALL_LIMIT - 1);
  localparam logic [HIST_AW:0] HIST_FULL    = (HIST_AW+1)'(HIST_DEPTH);

  state_e             state_q, state_d;
  logic [2:0]         status_q, status_d;
  logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;
  logic [CNT_W-1:0]   fetch_count_q, fetch_count_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [PC_W-1:0]    final_pc_q, final_pc_d;
  logic [PC_W-1:0]    last_pc_q, last_pc_d;
  logic               first_fetch_q, first_fetch_d;
  logic [HIST_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [HIST_AW:0]   hist_count_q, hist_count_d;
  logic [PC_W-1:0]    hist_q [HIST_DEPTH];
  logic [PC_W-1:0]    hist_d [HIST_DEPTH];

  logic               new_pc;
  logic [HIST_AW-1:0] rd_ptr;

  assign new_pc = first_fetch_q || (fetch_pc_i != last_pc_q);

  always_comb begin
    state_d       = state_q;
    status_d      = status_q;
    cycle_count_d = cycle_count_q;
    fetch_count_d = fetch_count_q;
    stall_cnt_d   = stall_cnt_q;
    final_pc_d    = final_pc_q;
    last_pc_d     = last_pc_q;
    first_fetch_d = first_fetch_q;
    wr_ptr_d      = wr_ptr_q;
    hist_count_d  = hist_count_q;
    hist_d        = hist_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d       = S_RUN;
          status_d      = ST_NONE;
          cycle_count_d = '0;
          fetch_count_d = '0;
          stall_cnt_d   = '0;
          final_pc_d    = '0;
          last_pc_d     = '0;
          first_fetch_d = 1'b1;
          wr_ptr_d      = '0;
          hist_count_d  = '0;
          for (int i = 0; i < HIST_DEPTH; i++) hist_d[i] = '0;
        end
      end
      S_RUN: begin
        if (cycle_count_q != '1) cycle_count_d = cycle_count_q + CNT_W'(1);
        if (fetch_valid_i) begin
          if (fetch_count_q != '1) fetch_count_d = fetch_count_q + CNT_W'(1);
          final_pc_d = fetch_pc_i;
          if (new_pc) begin
            hist_d[wr_ptr_q] = fetch_pc_i;
            wr_ptr_d         = wr_ptr_q + HIST_AW'(1);
            if (hist_count_q != HIST_FULL) hist_count_d = hist_count_q + (HIST_AW+1)'(1);
            stall_cnt_d   = '0;
            last_pc_d     = fetch_pc_i;
            first_fetch_d = 1'b0;
          end else if (stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
          end
        end
        // Verdict priority: pass, fail, timeout, hang.
        if (fetch_valid_i && fetch_pc_i == PASS_ADDR) begin
          state_d  = S_DONE;
          status_d = ST_PASS;
        end else if (fetch_valid_i && fetch_pc_i == FAIL_ADDR) begin
          state_d  = S_DONE;
          status_d = ST_FAIL;
        end else if (cycle_count_q == TIMEOUT_LAST) begin
          state_d  = S_DONE;
          status_d = ST_TIMEOUT;
        end else if (fetch_valid_i && !new_pc && stall_cnt_q == STALL_LAST) begin
          state_d  = S_DONE;
          status_d = ST_HANG;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      status_q      <= ST_NONE;
      cycle_count_q <= '0;
      fetch_count_q <= '0;
      stall_cnt_q   <= '0;
      final_pc_q    <= '0;
      last_pc_q     <= '0;
      first_fetch_q <= 1'b1;
      wr_ptr_q      <= '0;
      hist_count_q  <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) hist_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      status_q      <= status_d;
      cycle_count_q <= cycle_count_d;
      fetch_count_q <= fetch_count_d;
      stall_cnt_q   <= stall_cnt_d;
      final_pc_q    <= final_pc_d;
      last_pc_q     <= last_pc_d;
      first_fetch_q <= first_fetch_d;
      wr_ptr_q      <= wr_ptr_d;
      hist_count_q  <= hist_count_d;
      for (int i = 0; i < HIST_DEPTH; i++) hist_q[i] <= hist_d[i];
    end
  end

  // Most recent entry sits just behind the write pointer.
  assign rd_ptr    = wr_ptr_q - HIST_AW'(1) - hist_idx_i;
  assign hist_pc_o = ({1'b0, hist_idx_i} < hist_count_q) ? hist_q[rd_ptr] : '0;

  assign running_o     = (state_q == S_RUN);
  assign done_o        = (state_q == S_DONE);
  assign status_o      = status_q;
  assign cycle_count_o = cycle_count_q;
  assign fetch_count_o = fetch_count_q;
  assign final_pc_o    = final_pc_q;
  assign hist_count_o  = hist_count_q;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Directed bench for riscv_test_monitor: verdicts, priorities, timeout, hang, history, reset/restart.
module tb_riscv_test_monitor;

  localparam logic [31:0] PASS_PC = 32'h8000012c;
  localparam logic [31:0] FAIL_PC = 32'h80000130;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        fetch_valid_i = 1'b0;
  logic [31:0] fetch_pc_i = '0;
  logic [2:0]  hist_idx_i = '0;

  logic        running_o, done_o;
  logic [2:0]  status_o;
  logic [31:0] cycle_count_o, fetch_count_o, final_pc_o, hist_pc_o;
  logic [3:0]  hist_count_o;

  logic        b_running, b_done;
  logic [2:0]  b_status;
  logic [31:0] b_cycle, b_fetch, b_final, b_hist;
  logic [3:0]  b_hcount;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  riscv_test_monitor #(
    .TIMEOUT_CYCLES(20), .STALL_LIMIT(4), .HIST_DEPTH(8), .HIST_AW(3)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .fetch_valid_i(fetch_valid_i), .fetch_pc_i(fetch_pc_i), .hist_idx_i(hist_idx_i),
    .running_o(running_o), .done_o(done_o), .status_o(status_o),
    .cycle_count_o(cycle_count_o), .fetch_count_o(fetch_count_o),
    .final_pc_o(final_pc_o), .hist_pc_o(hist_pc_o), .hist_count_o(hist_count_o)
  );

  // Pass and fail share one address: pass must win.
  riscv_test_monitor #(
    .PASS_ADDR(32'h80000130), .FAIL_ADDR(32'h80000130)
  ) dut_pf (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .fetch_valid_i(fetch_valid_i), .fetch_pc_i(fetch_pc_i), .hist_idx_i(hist_idx_i),
    .running_o(b_running), .done_o(b_done), .status_o(b_status),
    .cycle_count_o(b_cycle), .fetch_count_o(b_fetch),
    .final_pc_o(b_final), .hist_pc_o(b_hist), .hist_count_o(b_hcount)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc);
    fetch_valid_i = 1'b1;
    fetch_pc_i    = pc;
    step();
    fetch_valid_i = 1'b0;
  endtask

  task automatic start_run();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) step();
    rst_i = 1'b0;
    total++; if ({running_o, done_o} !== 2'b00) begin bad++; $display("FAIL reset_state got=%b want=00", {running_o, done_o}); end
    total++; if (status_o !== 3'd0 || cycle_count_o !== 0 || fetch_count_o !== 0 || final_pc_o !== 0 || hist_count_o !== 0)
      begin bad++; $display("FAIL reset_outputs status=%0d cyc=%0d fetch=%0d pc=%h hc=%0d want all 0", status_o, cycle_count_o, fetch_count_o, final_pc_o, hist_count_o); end
    fetch(PASS_PC);
    total++; if (done_o !== 1'b0 || fetch_count_o !== 0) begin bad++; $display("FAIL idle_ignores_fetch done=%b fetch=%0d want 0 0", done_o, fetch_count_o); end
  endtask

  task automatic test_pass();
    start_run();
    total++; if (running_o !== 1'b1 || cycle_count_o !== 0) begin bad++; $display("FAIL start_run running=%b cyc=%0d want 1 0", running_o, cycle_count_o); end
    step(); step();
    fetch(32'h80000000);
    fetch(32'h80000004);
    fetch(32'h80000008);
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL pass_early_done got=%b want 0", done_o); end
    fetch(PASS_PC);
    total++; if (done_o !== 1'b1 || running_o !== 1'b0 || status_o !== 3'd1) begin bad++; $display("FAIL pass_status done=%b run=%b status=%0d want 1 0 1", done_o, running_o, status_o); end
    total++; if (final_pc_o !== PASS_PC || fetch_count_o !== 4 || cycle_count_o !== 6) begin bad++; $display("FAIL pass_counts pc=%h fetch=%0d cyc=%0d want 8000012c 4 6", final_pc_o, fetch_count_o, cycle_count_o); end
    hist_idx_i = 3'd0; #1;
    total++; if (hist_count_o !== 4 || hist_pc_o !== PASS_PC) begin bad++; $display("FAIL pass_hist0 hc=%0d pc=%h want 4 8000012c", hist_count_o, hist_pc_o); end
    hist_idx_i = 3'd3; #1;
    total++; if (hist_pc_o !== 32'h80000000) begin bad++; $display("FAIL pass_hist3 got=%h want 80000000", hist_pc_o); end
    fetch(FAIL_PC);
    step();
    total++; if (status_o !== 3'd1 || fetch_count_o !== 4 || final_pc_o !== PASS_PC) begin bad++; $display("FAIL done_frozen status=%0d fetch=%0d pc=%h want 1 4 8000012c", status_o, fetch_count_o, final_pc_o); end
  endtask

  task automatic test_fail_priority();
    start_run();
    total++; if (running_o !== 1'b1 || cycle_count_o !== 0 || fetch_count_o !== 0 || status_o !== 0 || hist_count_o !== 0)
      begin bad++; $display("FAIL restart_clear run=%b cyc=%0d fetch=%0d status=%0d hc=%0d want 1 0 0 0 0", running_o, cycle_count_o, fetch_count_o, status_o, hist_count_o); end
    fetch(FAIL_PC);
    total++; if (status_o !== 3'd2 || done_o !== 1'b1) begin bad++; $display("FAIL fail_status status=%0d done=%b want 2 1", status_o, done_o); end
    total++; if (b_status !== 3'd1 || b_done !== 1'b1) begin bad++; $display("FAIL pass_over_fail status=%0d done=%b want 1 1", b_status, b_done); end
  endtask

  task automatic test_timeout();
    int n;
    start_run();
    n = 0;
    while (!done_o && n < 40) begin step(); n++; end
    total++; if (n !== 20) begin bad++; $display("FAIL timeout_latency cycles=%0d want 20", n); end
    total++; if (status_o !== 3'd3 || cycle_count_o !== 20 || fetch_count_o !== 0) begin bad++; $display("FAIL timeout_status status=%0d cyc=%0d fetch=%0d want 3 20 0", status_o, cycle_count_o, fetch_count_o); end
    start_run();
    repeat (19) step();
    total++; if (done_o !== 1'b0 || cycle_count_o !== 19) begin bad++; $display("FAIL collision_pre done=%b cyc=%0d want 0 19", done_o, cycle_count_o); end
    fetch(PASS_PC);
    total++; if (status_o !== 3'd1 || cycle_count_o !== 20) begin bad++; $display("FAIL pass_over_timeout status=%0d cyc=%0d want 1 20", status_o, cycle_count_o); end
  endtask

  task automatic test_hang();
    start_run();
    repeat (4) fetch(32'h80000040);
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL hang_early done=%b want 0", done_o); end
    fetch(32'h80000040);
    total++; if (status_o !== 3'd4 || done_o !== 1'b1 || fetch_count_o !== 5 || hist_count_o !== 1)
      begin bad++; $display("FAIL hang_status status=%0d done=%b fetch=%0d hc=%0d want 4 1 5 1", status_o, done_o, fetch_count_o, hist_count_o); end
    hist_idx_i = 3'd1; #1;
    total++; if (hist_pc_o !== 32'h0) begin bad++; $display("FAIL hist_beyond_count got=%h want 0", hist_pc_o); end
    start_run();
    repeat (4) fetch(32'h80000040);
    fetch(32'h80000044);
    fetch(32'h80000040);
    total++; if (done_o !== 1'b0 || status_o !== 3'd0 || hist_count_o !== 3) begin bad++; $display("FAIL no_hang done=%b status=%0d hc=%0d want 0 0 3", done_o, status_o, hist_count_o); end
  endtask

  task automatic test_reset_mid_run();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    total++; if (running_o !== 0 || done_o !== 0 || status_o !== 0 || cycle_count_o !== 0 || fetch_count_o !== 0 || final_pc_o !== 0 || hist_count_o !== 0)
      begin bad++; $display("FAIL reset_mid_run run=%b done=%b status=%0d cyc=%0d fetch=%0d pc=%h hc=%0d want all 0", running_o, done_o, status_o, cycle_count_o, fetch_count_o, final_pc_o, hist_count_o); end
    fetch(32'h80000050);
    total++; if (running_o !== 0 || fetch_count_o !== 0 || final_pc_o !== 0) begin bad++; $display("FAIL reset_idle_fetch run=%b fetch=%0d pc=%h want 0 0 0", running_o, fetch_count_o, final_pc_o); end
  endtask

  task automatic test_hist_wrap();
    start_run();
    for (int i = 0; i < 10; i++) fetch(32'h80001000 + 32'(4 * i));
    fetch(32'h80001024);
    total++; if (hist_count_o !== 8 || fetch_count_o !== 11 || done_o !== 1'b0) begin bad++; $display("FAIL wrap_count hc=%0d fetch=%0d done=%b want 8 11 0", hist_count_o, fetch_count_o, done_o); end
    hist_idx_i = 3'd0; #1;
    total++; if (hist_pc_o !== 32'h80001024) begin bad++; $display("FAIL wrap_idx0 got=%h want 80001024", hist_pc_o); end
    hist_idx_i = 3'd1; #1;
    total++; if (hist_pc_o !== 32'h80001020) begin bad++; $display("FAIL wrap_idx1 got=%h want 80001020", hist_pc_o); end
    hist_idx_i = 3'd7; #1;
    total++; if (hist_pc_o !== 32'h80001008) begin bad++; $display("FAIL wrap_idx7 got=%h want 80001008", hist_pc_o); end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail_priority();
    test_timeout();
    test_hang();
    test_reset_mid_run();
    test_hist_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
